i2c_cfg_sequencer: RTL and testbench
====================================

// Module: i2c_cfg_sequencer
// PURPOSE
//  Drives the I2C write-master's write_valid/write_ready port to configure an external
//    device (mic/codec) after power-up.
//  Walks a constant table of (reg_addr, data) entries and issues one I2C write per entry.
//  Checks the master's NACK error flag after each write. Retries failed writes and
//    reports done/fail status.
//  Runs on the same slow I2C clock as the master; sits between the top level and the master.
// PARAMETERS
//  NUM_REGS        11     number of table entries to write (1..16)
//  SLAVE_ADDR      7'h1A  7-bit device address driven on slav_addr
//  STARTUP_DELAY   200    clk cycles waited after start before the first write (10 ms at 20 kHz)
//  MAX_RETRIES     3      extra attempts per entry after a failure (total attempts = 1+MAX_RETRIES)
//  TIMEOUT_CYCLES  64     max cycles for write_ready to return high after a handshake
// PORTS
//  clk             in   1  I2C-rate clock, shared with the I2C master
//  rst_n           in   1  asynchronous, active-low reset
//  start           in   1  one-cycle pulse: begin (or restart) the configuration sequence
//  slav_addr       out  7  to master; constant SLAVE_ADDR
//  read_not_write  out  1  to master; constant 0 (write only)
//  reg_addr        out  8  to master; register address of the current entry
//  write_data      out  8  to master; data of the current entry
//  write_valid     out  1  to master; request for one write transaction
//  write_ready     in   1  from master; high only while the master is idle
//  error           in   1  from master; NACK flag, valid on the first idle cycle after a transfer
//  busy            out  1  sequence in progress
//  done            out  1  all entries written and ACKed (sticky until start or reset)
//  fail            out  1  an entry exhausted its retries (sticky until start or reset)
//  fail_index      out  4  index of the failing entry; 0 when fail=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0 except slav_addr=SLAVE_ADDR;
//    entry index, retry counter and timers are 0.
//  FSM states: IDLE, PWR_WAIT, ISSUE, WAIT_BUSY, WAIT_IDLE, CHECK, DONE, FAIL.
//  IDLE / DONE / FAIL on start:
//    go to PWR_WAIT; clear done, fail and fail_index; set idx=0, retry=0.
//    start in any other state is ignored.
//  PWR_WAIT: count STARTUP_DELAY cycles, then go to ISSUE.
//  ISSUE:
//    write_valid=1; reg_addr/write_data = table[idx]; outputs stable while valid.
//    On the handshake cycle (write_valid & write_ready): go to WAIT_BUSY.
//    write_valid is 0 from the next cycle on.
//  WAIT_BUSY: wait for write_ready=0 (master has left its idle state), then go to WAIT_IDLE.
//  WAIT_IDLE: wait for write_ready=1, then go to CHECK.
//  Timeout: WAIT_BUSY and WAIT_IDLE share one timer started at the handshake.
//    If the timer reaches TIMEOUT_CYCLES, go to CHECK as a failure.
//  CHECK (exactly the first cycle of write_ready=1; the master clears error on that clock edge):
//    Sample error. Result is failure if error=1 or the timer timed out.
//    Success, idx==NUM_REGS-1: go to DONE; done=1.
//    Success, otherwise: idx+1, retry=0, go to ISSUE.
//    Failure, retry<MAX_RETRIES: retry+1, go to ISSUE with the same idx.
//    Failure, retry==MAX_RETRIES: go to FAIL; fail=1; fail_index=idx.
//  busy=1 in PWR_WAIT through CHECK.
//  Nominal latency per write: 1 handshake cycle + 32 master cycles + 1 CHECK cycle.
//  Reset mid-transfer: the sequencer aborts immediately. The master finishes its own frame;
//    the first ISSUE after restart waits on write_ready, so no frame overlap occurs.
// CONFIGURATION
//  I2C_CFG_HOST_WRITE_EN (macro)
//    Defined: adds ports host_reg_addr[8], host_data[8], host_valid and host_ready.
//      Host writes are accepted only in DONE or FAIL; the ROM sequence has absolute priority.
//      host_ready=1 in DONE/FAIL while no host write is pending.
//      On a host handshake the request is latched and issued through ISSUE..CHECK,
//        with no retries.
//      After the host write: return to the prior DONE/FAIL state. A NACK sets fail=1
//        and fail_index=4'hF.
//    Undefined: the host ports and logic are absent; DONE/FAIL react only to start.
// STRUCTURE
//  Package i2c_cfg_pkg:
//    typedef struct packed {logic [7:0] reg_addr; logic [7:0] data;} cfg_entry_t;
//    localparam cfg_entry_t CFG_TABLE[16];
//    FSM state enum typedef.
//  Sub-module i2c_cfg_rom: combinational idx -> cfg_entry_t lookup from CFG_TABLE
//    (swappable per device).
// TESTING
//  Bench: cycle-accurate master model (write_ready low for 32 cycles after a handshake;
//    error set for one idle cycle).
//  1. rst_n released, start pulse, error always 0:
//     first write_valid at cycle STARTUP_DELAY+1; 11 writes in table order;
//     then done=1, busy=0, fail=0.
//  2. error=1 on entry 2, first attempt only:
//     entry 2 issued twice with the same reg_addr/data; done=1; 12 handshakes in total.
//  3. error=1 always on entry 4, MAX_RETRIES=3:
//     4 attempts on entry 4; fail=1, fail_index=4; entry 5 never issued.
//  4. write_ready held low after a handshake:
//     timeout after 64 cycles counts as a failure and a retry is issued.
//  5. rst_n=0 during a transfer of entry 6:
//     busy/write_valid/done are 0 in the same cycle.
//     After reset, start restarts at entry 0 and waits for write_ready before the handshake.
//  6. I2C_CFG_HOST_WRITE_EN, host_valid during the sequence:
//     host_ready=0 until done.
//     Then reg 0x05 / data 0xAA produces exactly one write with those values; done stays 1.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared types, FSM states and the device register table
// used by i2c_cfg_sequencer.
package i2c_cfg_pkg;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    // Codec bring-up: reset first, activate last; unused slots are zero.
    localparam cfg_entry_t CFG_TABLE [16] = '{
        '{8'h1E, 8'h00}, '{8'h00, 8'h17}, '{8'h02, 8'h17}, '{8'h04, 8'h79},
        '{8'h06, 8'h79}, '{8'h08, 8'h14}, '{8'h0A, 8'h00}, '{8'h0C, 8'h00},
        '{8'h0E, 8'h02}, '{8'h10, 8'h00}, '{8'h12, 8'h01}, '{8'h00, 8'h00},
        '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00}
    };

    typedef enum logic [2:0] {
        IDLE, PWR_WAIT, ISSUE, WAIT_BUSY, WAIT_IDLE, CHECK, DONE, FAIL
    } state_t;

endpackage

// File: rtl/i2c_cfg_if.sv
// i2c_cfg_if: write request port between the config sequencer and
// the I2C write master.
interface i2c_cfg_if;
    logic [6:0] slav_addr;
    logic       read_not_write;
    logic [7:0] reg_addr;
    logic [7:0] write_data;
    logic       write_valid;
    logic       write_ready;
    logic       error;

    modport master (
        output slav_addr, read_not_write, reg_addr, write_data, write_valid,
        input  write_ready, error
    );

    modport slave (
        input  slav_addr, read_not_write, reg_addr, write_data, write_valid,
        output write_ready, error
    );
endinterface

// File: rtl/i2c_cfg_rom.sv
// i2c_cfg_rom: combinational lookup of one configuration table entry.
module i2c_cfg_rom
    import i2c_cfg_pkg::*;
(
    input  logic [3:0] idx,
    output cfg_entry_t entry
);
    assign entry = CFG_TABLE[idx];
endmodule

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: writes CFG_TABLE to the device with per-entry retry.
// Define I2C_CFG_HOST_WRITE_EN to add single host writes after the sequence.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         NUM_REGS       = 11,
    parameter logic [6:0] SLAVE_ADDR     = 7'h1A,
    parameter int         STARTUP_DELAY  = 200,
    parameter int         MAX_RETRIES    = 3,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    i2c_cfg_if.master  bus,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] fail_index
`ifdef I2C_CFG_HOST_WRITE_EN
    ,
    input  logic [7:0] host_reg_addr,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready
`endif
);
    localparam int CW = 16;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        to_q, to_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [3:0]  fidx_q, fidx_d;
    logic        fail_now;
    cfg_entry_t  rom_e;
    cfg_entry_t  cur_e;

    i2c_cfg_rom u_rom (
        .idx   (idx_q),
        .entry (rom_e)
    );

`ifdef I2C_CFG_HOST_WRITE_EN
    logic       host_q, host_d;
    logic       hret_q, hret_d;
    logic [7:0] haddr_q, haddr_d;
    logic [7:0] hdata_q, hdata_d;

    // start wins over a simultaneous host request
    assign host_ready = (state_q == DONE || state_q == FAIL) && !start;

    always_comb begin
        cur_e = rom_e;
        if (host_q) cur_e = '{reg_addr: haddr_q, data: hdata_q};
    end
`else
    assign cur_e = rom_e;
`endif

    assign fail_now           = err_q | to_q;
    assign bus.slav_addr      = SLAVE_ADDR;
    assign bus.read_not_write = 1'b0;
    assign bus.write_valid    = (state_q == ISSUE);
    assign bus.reg_addr       = bus.write_valid ? cur_e.reg_addr : 8'h00;
    assign bus.write_data     = bus.write_valid ? cur_e.data : 8'h00;
    assign busy = (state_q == PWR_WAIT) || (state_q == ISSUE) ||
                  (state_q == WAIT_BUSY) || (state_q == WAIT_IDLE) ||
                  (state_q == CHECK);
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_index = fidx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        to_d    = to_q;
        done_d  = done_q;
        fail_d  = fail_q;
        fidx_d  = fidx_q;
`ifdef I2C_CFG_HOST_WRITE_EN
        host_d  = host_q;
        hret_d  = hret_q;
        haddr_d = haddr_q;
        hdata_d = hdata_q;
`endif
        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_d = PWR_WAIT;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    fidx_d  = 4'h0;
                    idx_d   = 4'h0;
                    retry_d = 4'h0;
                    cnt_d   = '0;
                end
`ifdef I2C_CFG_HOST_WRITE_EN
                else if (host_ready && host_valid) begin
                    host_d  = 1'b1;
                    hret_d  = (state_q == FAIL);
                    haddr_d = host_reg_addr;
                    hdata_d = host_data;
                    state_d = ISSUE;
                end
`endif
            end
            PWR_WAIT: begin
                if (cnt_q == CW'(STARTUP_DELAY - 1)) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                if (bus.write_ready) begin
                    state_d = WAIT_BUSY;
                    cnt_d   = CW'(1);
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.write_ready) begin
                    state_d = WAIT_IDLE;
                end else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
                    state_d = CHECK;
                    to_d    = 1'b1;
                end
            end
            WAIT_IDLE: begin
                cnt_d = cnt_q + 1'b1;
                // error is only valid on the first idle cycle
                if (bus.write_ready) begin
                    state_d = CHECK;
                    err_d   = bus.error;
                end else if (cnt_q >= CW'(TIMEOUT_CYCLES)) begin
                    state_d = CHECK;
                    to_d    = 1'b1;
                end
            end
            CHECK: begin
`ifdef I2C_CFG_HOST_WRITE_EN
                if (host_q) begin
                    host_d  = 1'b0;
                    state_d = hret_q ? FAIL : DONE;
                    if (fail_now) begin
                        fail_d = 1'b1;
                        fidx_d = 4'hF;
                    end
                end else
`endif
                if (!fail_now) begin
                    if (idx_q == 4'(NUM_REGS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        retry_d = 4'h0;
                        state_d = ISSUE;
                    end
                end else if (retry_q < 4'(MAX_RETRIES)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ISSUE;
                end else begin
                    state_d = FAIL;
                    fail_d  = 1'b1;
                    fidx_d  = idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'h0;
            retry_q <= 4'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            fidx_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            fidx_q  <= fidx_d;
        end
    end

`ifdef I2C_CFG_HOST_WRITE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_q  <= 1'b0;
            hret_q  <= 1'b0;
            haddr_q <= 8'h00;
            hdata_q <= 8'h00;
        end else begin
            host_q  <= host_d;
            hret_q  <= hret_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: directed scenarios against a cycle-accurate
// write-master model (32 busy cycles per frame, one-cycle NACK flag).
module tb_i2c_cfg_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, fail;
    logic [3:0] fail_index;
`ifdef I2C_CFG_HOST_WRITE_EN
    logic [7:0] host_reg_addr = 8'h00;
    logic [7:0] host_data     = 8'h00;
    logic       host_valid    = 1'b0;
    logic       host_ready;
`endif

    i2c_cfg_if bus ();

    i2c_cfg_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_index (fail_index)
`ifdef I2C_CFG_HOST_WRITE_EN
        ,
        .host_reg_addr (host_reg_addr),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [7:0] T_ADDR [11] = '{
        8'h1E, 8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12
    };
    localparam logic [7:0] T_DATA [11] = '{
        8'h00, 8'h17, 8'h17, 8'h79, 8'h79, 8'h14, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01
    };

    int passed = 0;
    int total  = 0;

    // master model state; err_mode: 0 none, 1 NACK entry 2 once,
    // 2 NACK entry 4 always, 3 hang on first attempt of entry 3
    int         err_mode = 0;
    int         base     = 0;
    int         cyc      = 0;
    int         m_cnt    = 0;
    logic       m_err    = 1'b0;
    logic       m_pend   = 1'b0;
    logic [7:0] hs_addr [$];
    logic [7:0] hs_data [$];
    int         hs_cyc  [$];

    assign bus.write_ready = (m_cnt == 0);
    assign bus.error       = m_err;

    function automatic int prior(input logic [7:0] a);
        int n = 0;
        for (int i = base; i < hs_addr.size(); i++)
            if (hs_addr[i] == a) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_err <= m_pend;
        end else begin
            m_err <= 1'b0;
            if (bus.write_valid) begin
                m_pend <= (err_mode == 1 && bus.reg_addr == T_ADDR[2] &&
                           prior(bus.reg_addr) == 0) ||
                          (err_mode == 2 && bus.reg_addr == T_ADDR[4]);
                m_cnt  <= (err_mode == 3 && bus.reg_addr == T_ADDR[3] &&
                           prior(bus.reg_addr) == 0) ? 100 : 32;
                hs_addr.push_back(bus.reg_addr);
                hs_data.push_back(bus.write_data);
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int n);
        n = 0;
        while (!(done | fail) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_hs(input int cnt, input int bound);
        int n = 0;
        while (hs_addr.size() - base < cnt && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if ({busy, done, fail} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, fail}); else passed++;
        total++; if (fail_index !== 4'h0) $display("FAIL reset_fail_index: got %0h want 0", fail_index); else passed++;
        total++; if (bus.write_valid !== 1'b0 || bus.read_not_write !== 1'b0) $display("FAIL reset_valid: got %b%b want 00", bus.write_valid, bus.read_not_write); else passed++;
        total++; if (bus.slav_addr !== 7'h1A) $display("FAIL reset_slav_addr: got %0h want 1a", bus.slav_addr); else passed++;
        total++; if ({bus.reg_addr, bus.write_data} !== 16'h0000) $display("FAIL reset_addr_data: got %0h want 0", {bus.reg_addr, bus.write_data}); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal;
        int n;
        int bad = 0;
        err_mode = 0;
        base = hs_addr.size();
        pulse_start();
        n = 0;
        while (!bus.write_valid && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (n != 200) $display("FAIL first_valid_delay: got %0d want 200", n); else passed++;
        total++; if (bus.reg_addr !== T_ADDR[0] || bus.write_data !== T_DATA[0]) $display("FAIL first_entry: got %0h/%0h want %0h/%0h", bus.reg_addr, bus.write_data, T_ADDR[0], T_DATA[0]); else passed++;
        wait_end(600, n);
        total++; if ({done, busy, fail} !== 3'b100) $display("FAIL nominal_status: got %b want 100", {done, busy, fail}); else passed++;
        total++; if (hs_addr.size() - base != 11) $display("FAIL nominal_count: got %0d want 11", hs_addr.size() - base); else passed++;
        for (int i = 0; i < 11; i++)
            if (base + i >= hs_addr.size() || hs_addr[base + i] !== T_ADDR[i] || hs_data[base + i] !== T_DATA[i]) bad++;
        total++; if (bad != 0) $display("FAIL nominal_order: got %0d bad entries want 0", bad); else passed++;
    endtask

    task automatic test_retry_once;
        int n;
        int j;
        int bad = 0;
        err_mode = 1;
        base = hs_addr.size();
        pulse_start();
        wait_end(900, n);
        total++; if ({done, fail} !== 2'b10) $display("FAIL retry_status: got %b want 10", {done, fail}); else passed++;
        total++; if (hs_addr.size() - base != 12) $display("FAIL retry_count: got %0d want 12", hs_addr.size() - base); else passed++;
        for (int i = 0; i < 12; i++) begin
            j = (i < 3) ? i : i - 1;
            if (base + i >= hs_addr.size() || hs_addr[base + i] !== T_ADDR[j] || hs_data[base + i] !== T_DATA[j]) bad++;
        end
        total++; if (bad != 0) $display("FAIL retry_order: got %0d bad entries want 0", bad); else passed++;
    endtask

    task automatic test_exhaust;
        int n;
        int j;
        int bad = 0;
        err_mode = 2;
        base = hs_addr.size();
        pulse_start();
        wait_end(900, n);
        total++; if ({done, fail, busy} !== 3'b010) $display("FAIL exhaust_status: got %b want 010", {done, fail, busy}); else passed++;
        total++; if (fail_index !== 4'h4) $display("FAIL exhaust_index: got %0h want 4", fail_index); else passed++;
        total++; if (hs_addr.size() - base != 8) $display("FAIL exhaust_count: got %0d want 8", hs_addr.size() - base); else passed++;
        for (int i = 0; i < 8; i++) begin
            j = (i < 4) ? i : 4;
            if (base + i >= hs_addr.size() || hs_addr[base + i] !== T_ADDR[j]) bad++;
        end
        for (int i = base; i < hs_addr.size(); i++)
            if (hs_addr[i] == T_ADDR[5]) bad++;
        total++; if (bad != 0) $display("FAIL exhaust_order: got %0d bad entries want 0", bad); else passed++;
        total++; if (bus.write_valid !== 1'b0) $display("FAIL exhaust_valid: got %b want 0", bus.write_valid); else passed++;
    endtask

    task automatic test_timeout;
        int n;
        int hcyc;
        err_mode = 3;
        base = hs_addr.size();
        pulse_start();
        wait_hs(4, 600);
        hcyc = hs_cyc[base + 3];
        n = 0;
        while (!bus.write_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (n < 64 || n > 66) $display("FAIL timeout_delay: got %0d want 64..66", n); else passed++;
        total++; if (bus.reg_addr !== T_ADDR[3]) $display("FAIL timeout_retry_addr: got %0h want %0h", bus.reg_addr, T_ADDR[3]); else passed++;
        total++; if (hs_addr.size() - base != 4) $display("FAIL timeout_no_early_hs: got %0d want 4", hs_addr.size() - base); else passed++;
        wait_end(900, n);
        total++; if ({done, fail} !== 2'b10) $display("FAIL timeout_status: got %b want 10", {done, fail}); else passed++;
        total++; if (hs_addr.size() - base != 12) $display("FAIL timeout_count: got %0d want 12", hs_addr.size() - base); else passed++;
        total++; if (hs_cyc[base + 4] - hcyc != 101) $display("FAIL timeout_retry_gap: got %0d want 101", hs_cyc[base + 4] - hcyc); else passed++;
        total++; if (hs_addr[base + 4] !== T_ADDR[3]) $display("FAIL timeout_retry_entry: got %0h want %0h", hs_addr[base + 4], T_ADDR[3]); else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        err_mode = 0;
        base = hs_addr.size();
        pulse_start();
        wait_hs(7, 800);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, bus.write_valid, done, fail} !== 4'b0000) $display("FAIL midreset_outputs: got %b want 0000", {busy, bus.write_valid, done, fail}); else passed++;
        total++; if (bus.write_ready !== 1'b0) $display("FAIL midreset_master_busy: got %b want 0", bus.write_ready); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = hs_addr.size();
        pulse_start();
        wait_hs(1, 400);
        total++; if (hs_addr.size() - base < 1 || hs_addr[base] !== T_ADDR[0]) $display("FAIL midreset_restart_entry: got %0d hs want entry %0h", hs_addr.size() - base, T_ADDR[0]); else passed++;
        wait_end(600, n);
        total++; if ({done, fail} !== 2'b10 || hs_addr.size() - base != 11) $display("FAIL midreset_complete: got %b/%0d want 10/11", {done, fail}, hs_addr.size() - base); else passed++;
    endtask

`ifdef I2C_CFG_HOST_WRITE_EN
    task automatic test_host_write;
        int n;
        err_mode = 0;
        base = hs_addr.size();
        host_reg_addr = 8'h05;
        host_data     = 8'hAA;
        host_valid    = 1'b1;
        pulse_start();
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (host_ready) break;
        end
        total++; if (done !== 1'b1 || hs_addr.size() - base != 11) $display("FAIL host_ready_early: got done=%b hs=%0d want 1/11", done, hs_addr.size() - base); else passed++;
        @(posedge clk);
        #1 host_valid = 1'b0;
        wait_hs(12, 100);
        repeat (40) @(posedge clk);
        #1;
        total++; if (hs_addr.size() - base != 12) $display("FAIL host_count: got %0d want 12", hs_addr.size() - base); else passed++;
        total++; if (hs_addr[base + 11] !== 8'h05 || hs_data[base + 11] !== 8'hAA) $display("FAIL host_payload: got %0h/%0h want 05/aa", hs_addr[base + 11], hs_data[base + 11]); else passed++;
        total++; if ({done, fail, busy, host_ready} !== 4'b1001) $display("FAIL host_status: got %b want 1001", {done, fail, busy, host_ready}); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_retry_once();
        test_exhaust();
        test_timeout();
        test_reset_mid();
`ifdef I2C_CFG_HOST_WRITE_EN
        test_host_write();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
